// File: rtl/crc.sv
// Serial 8-bit LFSR CRC: absorbs DATA LSB first while ACTIVE is high, then shifts the CRC out LSB first under Valid.
// Define CRC_ACTIVE_ABORT_EN to let ACTIVE=1 during the output phase abort it and start a new message.
module crc #(
    parameter logic [7:0] Seed = 8'hD8,
    parameter logic [7:0] Taps = 8'b0100_0100
) (
    input  logic CLK,
    input  logic RST,
    input  logic DATA,
    input  logic ACTIVE,
    output logic CRC,
    output logic Valid
);

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t     state, next_state;
    logic [7:0] r, r_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       crc_nxt, valid_nxt;

    // One LFSR step: feedback enters at bit 7 and is XORed into every tapped lower bit.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic din);
        logic fb;
        fb        = din ^ cur[0];
        lfsr_step = {fb, cur[7:1] ^ (Taps[6:0] & {7{fb}})};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            r     <= Seed;
            cnt   <= 3'd0;
            CRC   <= 1'b0;
            Valid <= 1'b0;
        end else begin
            state <= next_state;
            r     <= r_nxt;
            cnt   <= cnt_nxt;
            CRC   <= crc_nxt;
            Valid <= valid_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:  next_state = ACTIVE ? SHIFT : IDLE;
            SHIFT: next_state = ACTIVE ? SHIFT : OUT;
            OUT: begin
`ifdef CRC_ACTIVE_ABORT_EN
                if (ACTIVE)
                    next_state = SHIFT;
                else
`endif
                if (cnt == 3'd0)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        r_nxt     = r;
        cnt_nxt   = cnt;
        crc_nxt   = CRC;
        valid_nxt = Valid;
        case (state)
            IDLE, SHIFT: begin
                if (ACTIVE) begin
                    r_nxt = lfsr_step(r, DATA);
                end else if (state == SHIFT) begin
                    crc_nxt   = r[0];
                    valid_nxt = 1'b1;
                    r_nxt     = {1'b0, r[7:1]};
                    cnt_nxt   = 3'd1;
                end
            end
            OUT: begin
`ifdef CRC_ACTIVE_ABORT_EN
                if (ACTIVE) begin
                    crc_nxt   = 1'b0;
                    valid_nxt = 1'b0;
                    r_nxt     = lfsr_step(Seed, DATA);
                    cnt_nxt   = 3'd0;
                end else
`endif
                // cnt wraps to 0 after the 8th bit; that edge closes the pulse and reloads the seed.
                if (cnt == 3'd0) begin
                    crc_nxt   = 1'b0;
                    valid_nxt = 1'b0;
                    r_nxt     = Seed;
                end else begin
                    crc_nxt = r[0];
                    r_nxt   = {1'b0, r[7:1]};
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: begin
                crc_nxt   = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_crc.sv
// Directed bench for the serial CRC; abort behaviour follows CRC_ACTIVE_ABORT_EN like the design.
module tb_crc;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic DATA = 1'b0;
    logic ACTIVE = 1'b0;
    logic CRC;
    logic Valid;

    int n_checks = 0;
    int n_fail   = 0;

    crc dut (
        .CLK   (CLK),
        .RST   (RST),
        .DATA  (DATA),
        .ACTIVE(ACTIVE),
        .CRC   (CRC),
        .Valid (Valid)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference LFSR: seed 0xD8, feedback mask 0xC4 (bit 7 plus taps 0x44).
    function automatic logic [7:0] model_crc(input logic [7:0] msg, input int nbits);
        logic [7:0] r;
        logic       fb;
        r = 8'hD8;
        for (int k = 0; k < nbits; k++) begin
            fb = msg[k] ^ r[0];
            r  = r >> 1;
            if (fb) r = r ^ 8'hC4;
        end
        return r;
    endfunction

    task automatic do_reset();
        RST    = 1'b1;
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic send(input logic [7:0] msg, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            ACTIVE = 1'b1;
            DATA   = msg[k];
            tick();
        end
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        tick();
    endtask

    task automatic get_crc(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check({tag, "_valid"}, {7'd0, Valid}, 8'h01);
            got[k] = CRC;
            tick();
        end
        check(tag, got, exp);
        check({tag, "_end_valid"}, {7'd0, Valid}, 8'h00);
        check({tag, "_end_crc"}, {7'd0, CRC}, 8'h00);
    endtask

    initial begin
        logic [7:0] m, m2, got;

        do_reset();
        check("reset_valid", {7'd0, Valid}, 8'h00);
        check("reset_crc", {7'd0, CRC}, 8'h00);

        // Idle with DATA toggling but no ACTIVE: nothing comes out.
        for (int k = 0; k < 3; k++) begin
            DATA = k[0];
            tick();
            check("idle_valid", {7'd0, Valid}, 8'h00);
            check("idle_crc", {7'd0, CRC}, 8'h00);
        end

        send(8'h00, 8);
        get_crc("zero_byte", 8'h14);

        // Single-bit message '1' from seed 0xD8 gives 0xA8.
        do_reset();
        send(8'h01, 1);
        get_crc("one_bit", 8'hA8);

        for (int i = 0; i < 10; i++) begin
            m = 8'($urandom);
            do_reset();
            send(m, 8);
            get_crc($sformatf("rand_%0d_%02h", i, m), model_crc(m, 8));
        end

        // Back-to-back messages rely on the automatic seed reload.
        do_reset();
        m  = 8'h5A;
        m2 = 8'hC3;
        send(m, 8);
        get_crc("b2b_first", model_crc(m, 8));
        send(m2, 8);
        get_crc("b2b_second", model_crc(m2, 8));

        // Reset after the third output bit aborts the output.
        do_reset();
        send(8'h00, 8);
        check("pre_rst_bit0", {7'd0, CRC}, 8'h00);
        tick();
        check("pre_rst_bit1", {7'd0, CRC}, 8'h00);
        tick();
        check("pre_rst_bit2", {7'd0, CRC}, 8'h01);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_out_rst_valid", {7'd0, Valid}, 8'h00);
        check("mid_out_rst_crc", {7'd0, CRC}, 8'h00);
        send(8'h00, 8);
        get_crc("after_out_rst", 8'h14);

        // Reset in the middle of a message discards the partial state.
        for (int k = 0; k < 4; k++) begin
            ACTIVE = 1'b1;
            DATA   = 1'b1;
            tick();
        end
        RST = 1'b1;
        tick();
        RST    = 1'b0;
        ACTIVE = 1'b0;
        tick();
        check("mid_shift_rst_valid", {7'd0, Valid}, 8'h00);
        send(8'h00, 8);
        get_crc("after_shift_rst", 8'h14);

        // ACTIVE raised during the output phase.
        do_reset();
        send(8'h00, 8);
`ifndef CRC_ACTIVE_ABORT_EN
        got = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check("ovl_valid", {7'd0, Valid}, 8'h01);
            got[k] = CRC;
            ACTIVE = (k >= 2 && k <= 4);
            DATA   = 1'b1;
            tick();
        end
        ACTIVE = 1'b0;
        check("ovl_crc_unchanged", got, 8'h14);
        check("ovl_end_valid", {7'd0, Valid}, 8'h00);
`else
        tick();
        tick();
        ACTIVE = 1'b1;
        DATA   = 1'b1;
        tick();
        check("abort_valid", {7'd0, Valid}, 8'h00);
        check("abort_crc", {7'd0, CRC}, 8'h00);
        ACTIVE = 1'b0;
        DATA   = 1'b0;
        tick();
        get_crc("abort_restart", 8'hA8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc.md
CRC -- requirements
Module: crc

Interface
REQ-001 Seed, default 8'hD8, initial LFSR value loaded on reset and at end of each output phase.
REQ-002 Taps, default 8'b0100_0100, feedback XOR tap mask (bit i set: XOR feedback into R[i]).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 DATA  input  1  serial message bit, LSB first, sampled when ACTIVE=1.
REQ-006 ACTIVE  input  1  high while message bits are presented; falling level ends message.
REQ-007 CRC  output  1  serial CRC bit, LSB first, registered.
REQ-008 Valid  output  1  high exactly while CRC carries a valid CRC bit, registered.

Function
REQ-009 Internal 8-bit register R, 3-bit bit counter, states IDLE, SHIFT, OUT.
REQ-010 In IDLE or SHIFT with ACTIVE=1: FB = DATA ^ R[0]; R[7] <= FB; for i=0..6, R[i] <= R[i+1] ^ (Taps[i] & FB); state -> SHIFT.
REQ-011 SHIFT with ACTIVE=0: state -> OUT; same edge CRC <= R[0], Valid <= 1, R <= {1'b0, R[7:1]}, counter <= 1.
REQ-012 OUT: each edge CRC <= R[0], R shifts right zero-filled, counter increments; 8 bits total, LSB of final CRC first.
REQ-013 Edge after 8th bit: Valid <= 0, CRC <= 0, R <= Seed, state -> IDLE.
REQ-014 IDLE with ACTIVE=0: R, CRC, Valid hold; CRC=0, Valid=0.
REQ-015 Latency: first CRC bit valid one edge after the first edge sampling ACTIVE=0 following message.
REQ-016 Message length arbitrary >=1 bit; zero-length (no ACTIVE) produces no output.
REQ-017 ACTIVE=1 during OUT ignored; DATA discarded; output completes all 8 bits (unless REQ-023 macro).
REQ-018 Valid is a contiguous 8-cycle pulse per message; never glitches between bits.

Reset
REQ-019 RST=1 at a rising edge: R <= Seed, CRC <= 0, Valid <= 0, counter <= 0, state <= IDLE.
REQ-020 Reset takes priority over ACTIVE and any state, including mid-SHIFT and mid-OUT (output aborted).
REQ-021 No asynchronous path; outputs are undefined only before the first reset edge.

Configuration
REQ-022 Macro CRC_ACTIVE_ABORT_EN selects OUT-phase behaviour on ACTIVE=1.
REQ-023 Defined: ACTIVE=1 in OUT aborts output next edge (Valid <= 0, CRC <= 0), R <= Seed then absorbs that DATA bit per REQ-010, state -> SHIFT.
REQ-024 Undefined: behaviour per REQ-017.

Verification
REQ-025 Reset, ACTIVE=1 for 8 cycles with DATA byte 0x00 LSB first, ACTIVE=0 -> Valid high 8 cycles, CRC bits 0,0,1,0,1,0,0,0 (0x14).
REQ-026 Ten random bytes, each preceded by reset -> serial CRC matches a bit-accurate LFSR model (Seed 0xD8, Taps 0x44).
REQ-027 Back-to-back messages without reset -> second CRC matches model seeded with 0xD8 (auto reload).
REQ-028 RST=1 after 3rd output bit -> Valid=0, CRC=0 next edge; subsequent 0x00 message yields 0x14.
REQ-029 ACTIVE=1 during OUT, macro undefined -> all 8 bits unchanged; macro defined -> Valid drops next edge.
